// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM state
// encodings, and the error-cause classification used when checking responses.
package dmem_pkg;

    // RV32I load/store funct3 codes (size in [1:0], unsigned flag in [2])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_RANGE    = 2'b11
    } err_cause_t;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for RV32I byte/half/word accesses.
// Ports:
//   we          in   1   1 = store, 0 = load
//   funct3      in   3   load/store size and sign
//   addr_lo     in   2   byte offset within the word
//   wdata       in   32  right-aligned store data
//   raw         in   32  word currently stored at the addressed index
//   byte_en     out  4   bytes to write for a store
//   wdata_shift out  32  store data replicated onto every candidate lane
//   rdata_ext   out  32  selected lane, sign/zero extended
//   misalign    out  1   half on odd address or word not on a word boundary
//   illegal     out  1   funct3 not valid for this direction
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_shift,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    // Lane selection, write strobes, extension and alignment checks
    always_comb begin
        byte_en     = 4'b0000;
        wdata_shift = 32'h0000_0000;
        rdata_ext   = 32'h0000_0000;
        misalign    = 1'b0;
        illegal     = ~f3_legal(we, funct3);

        case (addr_lo)
            2'b00:   lane_byte_s = raw[7:0];
            2'b01:   lane_byte_s = raw[15:8];
            2'b10:   lane_byte_s = raw[23:16];
            2'b11:   lane_byte_s = raw[31:24];
            default: lane_byte_s = 8'h00;
        endcase
        lane_half_s = addr_lo[1] ? raw[31:16] : raw[15:0];

        // Store data is replicated so the byte enables alone pick the lane
        case (funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_shift = {4{wdata[7:0]}};
            end
            2'b01: begin
                misalign    = addr_lo[0];
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_shift = {2{wdata[15:0]}};
            end
            2'b10: begin
                misalign    = (addr_lo != 2'b00);
                byte_en     = 4'b1111;
                wdata_shift = wdata;
            end
            default: begin
                misalign    = 1'b0;
                byte_en     = 4'b0000;
            end
        endcase

        case (funct3)
            F3_B:    rdata_ext = {{24{lane_byte_s[7]}}, lane_byte_s};
            F3_BU:   rdata_ext = {24'h00_0000, lane_byte_s};
            F3_H:    rdata_ext = {{16{lane_half_s[15]}}, lane_half_s};
            F3_HU:   rdata_ext = {16'h0000, lane_half_s};
            F3_W:    rdata_ext = raw;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface. Accepts one load/store at a
// time, waits LATENCY cycles, commits to the owned word array and returns a
// registered response that is held until the CPU accepts it.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I load/store funct3
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data; zero for stores and errors
//   resp_err          illegal funct3, misaligned or out-of-range access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_LAST    = 4'(LATENCY);

    state_t      state_r, state_s;
    logic [3:0]  wait_cnt_r, wait_cnt_s;
    logic        req_ready_s, resp_valid_s, resp_err_s;
    logic [31:0] resp_rdata_s;

    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic [AW-1:0] word_idx_s;
    logic [31:0]   raw_s;
    logic [3:0]    byte_en_s;
    logic [31:0]   wdata_shift_s;
    logic [31:0]   rdata_ext_s;
    logic          misalign_s;
    logic          illegal_s;
    logic          range_err_s;
    logic          err_s;
    logic          accept_s;
    logic          commit_s;

    assign word_idx_s  = addr_r[AW+1:2];
    assign raw_s       = mem[word_idx_s];
    assign range_err_s = (addr_r[31:2] >= DEPTH_LIMIT);
    assign err_s       = illegal_s | misalign_s | range_err_s;
    assign accept_s    = (state_r == ST_IDLE) & req_valid;
    assign commit_s    = (state_r == ST_ACCESS) & (wait_cnt_r == LAT_LAST);

    dmem_lane_align u_lane_align (
        .we          (we_r),
        .funct3      (funct3_r),
        .addr_lo     (addr_r[1:0]),
        .wdata       (wdata_r),
        .raw         (raw_s),
        .byte_en     (byte_en_s),
        .wdata_shift (wdata_shift_s),
        .rdata_ext   (rdata_ext_s),
        .misalign    (misalign_s),
        .illegal     (illegal_s)
    );

    // Next-state and next-output logic for IDLE -> ACCESS -> RESP
    always_comb begin
        state_s      = state_r;
        wait_cnt_s   = wait_cnt_r;
        req_ready_s  = req_ready;
        resp_valid_s = resp_valid;
        resp_rdata_s = resp_rdata;
        resp_err_s   = resp_err;

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s     = ST_ACCESS;
                    wait_cnt_s  = 4'd0;
                    req_ready_s = 1'b0;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (commit_s) begin
                    state_s      = ST_RESP;
                    wait_cnt_s   = 4'd0;
                    resp_valid_s = 1'b1;
                    resp_err_s   = err_s;
                    resp_rdata_s = (err_s | we_r) ? 32'h0000_0000 : rdata_ext_s;
                end else begin
                    wait_cnt_s   = wait_cnt_r + 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s      = ST_IDLE;
                    req_ready_s  = 1'b1;
                    resp_valid_s = 1'b0;
                    resp_err_s   = 1'b0;
                    resp_rdata_s = 32'h0000_0000;
                end else begin
                    state_s      = ST_RESP;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                wait_cnt_s   = 4'd0;
                req_ready_s  = 1'b1;
                resp_valid_s = 1'b0;
                resp_err_s   = 1'b0;
                resp_rdata_s = 32'h0000_0000;
            end
        endcase
    end

    // FSM state, wait counter and registered handshake/response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            req_ready  <= req_ready_s;
            resp_valid <= resp_valid_s;
            resp_rdata <= resp_rdata_s;
            resp_err   <= resp_err_s;
        end
    end

    // Request latch; the CPU may change req_* freely once accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end else begin
            we_r     <= we_r;
            funct3_r <= funct3_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
        end
    end

    // Byte-enabled array write; contents survive rst, but rst in the commit
    // cycle suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && commit_s && we_r && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem[word_idx_s][8*b +: 8] <= wdata_shift_s[8*b +: 8];
                end
            end
        end
    end

endmodule
